// File: rtl/jesd204_rx_cgs_pkg.sv
// Shared encodings and counter width for the JESD204 RX code group synchronisation block.
package jesd204_rx_cgs_pkg;

    typedef enum logic [1:0] {
        CGS_STATE_INIT  = 2'b00,
        CGS_STATE_CHECK = 2'b01,
        CGS_STATE_DATA  = 2'b10
    } cgs_state_e;

    localparam int unsigned CGS_CNT_W = 4;

endpackage

// File: rtl/jesd204_rx_cgs_mlane_lane.sv
// One lane of code group synchronisation: INIT/CHECK/DATA FSM, K and error run counters, sticky lost_sync.
//   state | meaning
//   INIT  | hunting for CGS_BEATS consecutive all-/K/ beats
//   CHECK | /K/ run found, waiting for the first non-/K/ beat
//   DATA  | synchronised; ERR_BEATS consecutive error beats drop back to INIT
module jesd204_rx_cgs_mlane_lane
    import jesd204_rx_cgs_pkg::*;
#(
    parameter int unsigned OCTETS_PER_BEAT = 4,
    parameter int unsigned CGS_BEATS       = 4,
    parameter int unsigned ERR_BEATS       = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [OCTETS_PER_BEAT-1:0] cgs,
    input  logic [OCTETS_PER_BEAT-1:0] err,
    input  logic                       lane_dis,
    input  logic                       ls_clear,
    output logic                       ready,
    output logic                       ready_nxt,
    output logic                       lost_sync,
    output logic [1:0]                 state
);

    cgs_state_e           state_q, state_d;
    logic [CGS_CNT_W-1:0] cgs_cnt_q, cgs_cnt_d;
    logic [CGS_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 lost_sync_q, lost_sync_d;
    logic                 k_beat, err_beat;

    assign k_beat   = (&cgs) & ~(|err);
    assign err_beat = |err;

    always_comb begin
        state_d     = state_q;
        cgs_cnt_d   = cgs_cnt_q;
        err_cnt_d   = err_cnt_q;
        lost_sync_d = lost_sync_q & ~ls_clear;
        if (lane_dis) begin
            state_d   = CGS_STATE_INIT;
            cgs_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            case (state_q)
                CGS_STATE_INIT: begin
                    if (!k_beat) begin
                        cgs_cnt_d = '0;
                    end else if (cgs_cnt_q == CGS_CNT_W'(CGS_BEATS - 1)) begin
                        state_d   = CGS_STATE_CHECK;
                        cgs_cnt_d = '0;
                    end else begin
                        cgs_cnt_d = cgs_cnt_q + 1'b1;
                    end
                end
                CGS_STATE_CHECK: begin
                    if (err_beat) begin
                        state_d   = CGS_STATE_INIT;
                        cgs_cnt_d = '0;
                    end else if (!k_beat) begin
                        state_d   = CGS_STATE_DATA;
                        err_cnt_d = '0;
                    end
                end
                CGS_STATE_DATA: begin
                    if (!err_beat) begin
                        err_cnt_d = '0;
                    end else if (err_cnt_q == CGS_CNT_W'(ERR_BEATS - 1)) begin
                        state_d     = CGS_STATE_INIT;
                        err_cnt_d   = '0;
                        cgs_cnt_d   = '0;
                        lost_sync_d = 1'b1;   // set wins over a same-cycle clear
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = CGS_STATE_INIT;
                    cgs_cnt_d = '0;
                    err_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CGS_STATE_INIT;
            cgs_cnt_q   <= '0;
            err_cnt_q   <= '0;
            lost_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cgs_cnt_q   <= cgs_cnt_d;
            err_cnt_q   <= err_cnt_d;
            lost_sync_q <= lost_sync_d;
        end
    end

    assign ready     = (state_q == CGS_STATE_DATA);
    assign ready_nxt = (state_d == CGS_STATE_DATA);
    assign lost_sync = lost_sync_q;
    assign state     = state_q;

endmodule

// File: rtl/jesd204_rx_cgs_mlane.sv
// Multi-lane JESD204 RX code group synchronisation with aggregate readiness.
// Define JESD204_RX_CGS_ERR_COUNT_EN to add per-lane saturating error counters (err_count/err_count_clear).
module jesd204_rx_cgs_mlane
    import jesd204_rx_cgs_pkg::*;
#(
    parameter int unsigned NUM_LANES       = 4,
    parameter int unsigned OCTETS_PER_BEAT = 4,
    parameter int unsigned CGS_BEATS       = 4,
    parameter int unsigned ERR_BEATS       = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_LANES*OCTETS_PER_BEAT-1:0] char_is_cgs,
    input  logic [NUM_LANES*OCTETS_PER_BEAT-1:0] char_is_error,
    input  logic [NUM_LANES-1:0]                 lane_disable,
    input  logic [NUM_LANES-1:0]                 lost_sync_clear,
`ifdef JESD204_RX_CGS_ERR_COUNT_EN
    input  logic [NUM_LANES-1:0]                 err_count_clear,
    output logic [8*NUM_LANES-1:0]               err_count,
`endif
    output logic [NUM_LANES-1:0]                 ready,
    output logic                                 all_ready,
    output logic [NUM_LANES-1:0]                 lost_sync,
    output logic [2*NUM_LANES-1:0]               state
);

    localparam int unsigned OPB = OCTETS_PER_BEAT;

    logic [NUM_LANES-1:0] ready_nxt;
    logic                 all_ready_q, all_ready_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        jesd204_rx_cgs_mlane_lane #(
            .OCTETS_PER_BEAT (OCTETS_PER_BEAT),
            .CGS_BEATS       (CGS_BEATS),
            .ERR_BEATS       (ERR_BEATS)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .cgs       (char_is_cgs[l*OPB +: OPB]),
            .err       (char_is_error[l*OPB +: OPB]),
            .lane_dis  (lane_disable[l]),
            .ls_clear  (lost_sync_clear[l]),
            .ready     (ready[l]),
            .ready_nxt (ready_nxt[l]),
            .lost_sync (lost_sync[l]),
            .state     (state[2*l +: 2])
        );

`ifdef JESD204_RX_CGS_ERR_COUNT_EN
        logic [7:0] err_count_q, err_count_d;
        logic       err_in_data;

        assign err_in_data = (state[2*l +: 2] == CGS_STATE_DATA) & (|char_is_error[l*OPB +: OPB])
                           & ~lane_disable[l];

        always_comb begin
            err_count_d = err_count_q;
            if (err_count_clear[l]) begin
                err_count_d = '0;
            end else if (err_in_data && err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                err_count_q <= '0;
            end else begin
                err_count_q <= err_count_d;
            end
        end

        assign err_count[8*l +: 8] = err_count_q;
`endif
    end

    // Built from next-state so all_ready moves on the same edge as ready.
    always_comb begin
        all_ready_d = (&(ready_nxt | lane_disable)) & ~(&lane_disable);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= all_ready_d;
        end
    end

    assign all_ready = all_ready_q;

endmodule

// File: doc/jesd204_rx_cgs_mlane.md
# jesd204_rx_cgs_mlane

Multi-lane, parametrised code group synchronisation (CGS) block for the JESD204 RX link layer. It sits after the per-lane 8b/10b decoders and before the ILAS/lane-alignment logic. It runs an independent CGS state machine per lane over a multi-octet datapath, with programmable acquisition and loss thresholds. It reports per-lane and aggregate readiness plus sticky loss-of-sync flags.

## Interface
- NUM_LANES, 4, number of lanes (1..32)
- OCTETS_PER_BEAT, 4, octets per lane per clock (1, 2, 4, 8)
- CGS_BEATS, 4, consecutive all-/K/ beats needed to leave INIT (1..15)
- ERR_BEATS, 3, consecutive error beats in DATA that drop sync (1..15)

- clk  input  1  link clock
- reset  input  1  synchronous, active-high reset
- char_is_cgs  input  NUM_LANES*OCTETS_PER_BEAT  octet is /K/ (lane l at bits [l*OPB +: OPB])
- char_is_error  input  NUM_LANES*OCTETS_PER_BEAT  octet has disparity/not-in-table error
- lane_disable  input  NUM_LANES  lane masked off
- lost_sync_clear  input  NUM_LANES  clear for sticky lost_sync
- ready  output  NUM_LANES  lane synchronised
- all_ready  output  1  all enabled lanes ready
- lost_sync  output  NUM_LANES  sticky: lane fell DATA→INIT
- state  output  2*NUM_LANES  per-lane state (debug)

## Operation
- Per-lane beat qualifiers: k_beat = &cgs & ~|err; err_beat = |err.
- States: INIT=2'b00, CHECK=2'b01, DATA=2'b10. 2'b11 is illegal and recovers to INIT.
- INIT:
  - cgs_cnt increments on k_beat; any other beat clears it.
  - On a k_beat with cgs_cnt==CGS_BEATS-1 → CHECK.
- CHECK (waiting for the end of CGS):
  - k_beat: stay.
  - err_beat → INIT, cgs_cnt=0.
  - Non-K, error-free beat (including a partial-K beat such as 4'b0001) → DATA.
- DATA:
  - err_beat increments err_cnt; any error-free beat clears it.
  - On an err_beat with err_cnt==ERR_BEATS-1 → INIT, and lost_sync set.
  - /K/ octets in DATA are legal and are not errors.
- ready[l] = (state==DATA).
- all_ready = &(ready | lane_disable) & ~&lane_disable.
- lane_disable[l]=1 forces lane l to INIT, clears its counters, and holds ready[l]=0. lost_sync is not set by a disable.
- lost_sync[l]:
  - Set on DATA→INIT.
  - Cleared by lost_sync_clear[l].
  - Simultaneous set and clear: set wins.
- Counters are 4 bits wide and cannot overflow, because thresholds are ≤15 and transitions occur at threshold.

## Timing
- All outputs registered. Every output resets to 0; state resets to INIT.
- A qualifying beat sampled at edge n changes state/ready at edge n, visible in cycle n+1. Latency is 1 clock.
- all_ready lags ready by 0 cycles (it is registered from next-state).
- Minimum acquisition time: CGS_BEATS K beats + 1 non-K beat.
- Reset asserted mid-operation: on the next edge all lanes return to INIT, counters are 0, and lost_sync is cleared.
- Reset dominates lane_disable and lost_sync_clear.

## Configuration
- JESD204_RX_CGS_ERR_COUNT_EN defined:
  - Adds output err_count [8*NUM_LANES] and input err_count_clear [NUM_LANES].
  - err_count holds per-lane 8-bit saturating (stops at 255) counts of err_beats seen in DATA.
  - Cleared by reset or err_count_clear; clear wins over increment.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package jesd204_rx_cgs_pkg holds the state encodings (CGS_STATE_INIT/CHECK/DATA) and the counter width constant (4).
- Sub-module jesd204_rx_cgs_mlane_lane implements one lane's FSM, counters and lost_sync. It is generated NUM_LANES times.
- The top level contains only slicing, the all_ready reduction and the optional counter hookup.

## Test plan
- Defaults, all lanes all-/K/ for 10 beats, then cgs=4'b0001 on every lane:
  - ready=4'hF one cycle after the partial beat.
  - all_ready=1, lost_sync=0.
- Lane 2 sends only 3 K beats, then data:
  - Lane 2 stays INIT, ready=4'b1011, all_ready=0.
  - After 4 K beats plus 1 data beat, all_ready=1.
- In DATA, lane 0 gets 2 error beats, 1 clean beat, then 2 error beats:
  - ready[0] stays 1.
  - A 3rd consecutive error beat gives ready[0]=0 and lost_sync[0]=1.
  - lost_sync[0] survives re-acquisition until lost_sync_clear[0].
- lane_disable=4'b1000 with lanes 0–2 synced:
  - all_ready=1, ready[3]=0, lost_sync[3]=0.
  - lane_disable=4'hF gives all_ready=0.
- Error beat during CHECK:
  - Lane returns to INIT and needs CGS_BEATS fresh K beats.
  - Reset pulse mid-DATA gives all outputs 0 next cycle.
- With JESD204_RX_CGS_ERR_COUNT_EN, 300 isolated error beats in DATA:
  - err_count=255 with ready held at 1.
  - err_count_clear gives 0.
